// File: rtl/hyperbus_responder.sv
// -----------------------------------------------------------------------------
// hyperbus_responder
//
// Purpose: behavioural HyperBus device model for synthesis/emulation. It
// receives a 48-bit command/address over three bus words, waits out the
// initial access latency and then streams read data or accepts masked write
// data from a 16-bit backing store. The burst address either increments
// linearly or wraps inside a 16-word block.
//
// Optional feature (compile-time macro HYPERBUS_RESPONDER_REGSPACE_EN):
// implements the register space (read-only ID0 and writable CR0). Without
// it, register-space commands are drained without effect.
//
// Ports:
//   clk_i      sole clock, rising edge
//   rst_i      synchronous active-high reset
//   cs_ni      chip select, active-low; one bus word per clk_i cycle
//   dq_i       CA word / write-data word
//   rwds_i     write byte mask (bit0 -> dq_i[7:0], bit1 -> dq_i[15:8]; 1 = masked)
//   lat_i      initial latency in cycles (0 behaves as 1)
//   add_lat_i  device requests doubled latency
//   dq_o       read data (registered)
//   dq_oe_o    dq_o drive enable
//   rwds_o     latency indicator during CA, read strobe during data
//   rwds_oe_o  rwds_o drive enable
// -----------------------------------------------------------------------------
module hyperbus_responder #(
    parameter int unsigned MemWords = 256,
    parameter logic [15:0] IdValue  = 16'h0C81
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cs_ni,
    input  logic [15:0] dq_i,
    input  logic [1:0]  rwds_i,
    input  logic [3:0]  lat_i,
    input  logic        add_lat_i,
    output logic [15:0] dq_o,
    output logic        dq_oe_o,
    output logic        rwds_o,
    output logic        rwds_oe_o
);

    localparam int unsigned AW = $clog2(MemWords);
    localparam logic [AW-1:0] LOW_MASK = AW'(15);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CA    = 3'd1;
    localparam logic [2:0] ST_LAT   = 3'd2;
    localparam logic [2:0] ST_READ  = 3'd3;
    localparam logic [2:0] ST_WRITE = 3'd4;
    localparam logic [2:0] ST_REGWR = 3'd5;
    localparam logic [2:0] ST_DRAIN = 3'd6;

    logic [2:0]    state_q, state_d;
    logic [4:0]    cnt_q, cnt_d;
    logic [31:0]   ca_q, ca_d;          // CA words 0 and 1; word 2 is used live
    logic [3:0]    lat_q, lat_d;
    logic          add_lat_q, add_lat_d;
    logic          is_read_q, is_read_d;
    logic          linear_q, linear_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [15:0]   dq_q, dq_d;
    logic [15:0]   mem_q [MemWords];

    logic [4:0]    lat_eff_s;
    logic [3:0]    lat_nz_s;
    logic [AW-1:0] addr_next_s;
    logic [AW-1:0] addr_ca_s;
    logic [15:0]   rd_data_s;
    logic          mem_we_s;
    logic          dq_oe_s, rwds_oe_s, rwds_s;

`ifdef HYPERBUS_RESPONDER_REGSPACE_EN
    logic [15:0]   cr0_q;
    logic          is_reg_q, is_reg_d;
    logic          reg_sel_q, reg_sel_d;
    logic          cr0_we_s;
`endif

    // Effective latency, burst address step and read-data source
    always_comb begin
        lat_nz_s    = (lat_q == 4'd0) ? 4'd1 : lat_q;
        lat_eff_s   = add_lat_q ? {lat_nz_s, 1'b0} : {1'b0, lat_nz_s};
        // Word address is {addr_upper, addr_lower}; only the low bits index the store
        addr_ca_s   = AW'({ca_q[28:0], dq_i[2:0]});
        if (linear_q) begin
            addr_next_s = addr_q + AW'(1);
        end else begin
            // Wrapped burst: only the low nibble advances
            addr_next_s = (addr_q & ~LOW_MASK) | ((addr_q + AW'(1)) & LOW_MASK);
        end
`ifdef HYPERBUS_RESPONDER_REGSPACE_EN
        if (is_reg_q) begin
            rd_data_s = reg_sel_q ? cr0_q : IdValue;
        end else begin
            rd_data_s = mem_q[addr_q];
        end
`else
        rd_data_s = mem_q[addr_q];
`endif
    end

    // Next-state and datapath control
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ca_d      = ca_q;
        lat_d     = lat_q;
        add_lat_d = add_lat_q;
        is_read_d = is_read_q;
        linear_d  = linear_q;
        addr_d    = addr_q;
        dq_d      = 16'h0000;
        mem_we_s  = 1'b0;
`ifdef HYPERBUS_RESPONDER_REGSPACE_EN
        is_reg_d  = is_reg_q;
        reg_sel_d = reg_sel_q;
        cr0_we_s  = 1'b0;
`endif
        if (cs_ni) begin
            // Deselect aborts whatever is in flight, including a partial CA
            state_d = ST_IDLE;
            cnt_d   = 5'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    ca_d[31:16] = dq_i;
                    lat_d       = lat_i;
                    add_lat_d   = add_lat_i;
                    cnt_d       = 5'd1;
                    state_d     = ST_CA;
                end
                ST_CA: begin
                    if (cnt_q == 5'd1) begin
                        ca_d[15:0] = dq_i;
                        cnt_d      = 5'd2;
                    end else begin
                        // Third CA word: full command is now known
                        is_read_d = ca_q[31];
                        linear_d  = ca_q[29];
                        addr_d    = addr_ca_s;
`ifdef HYPERBUS_RESPONDER_REGSPACE_EN
                        is_reg_d  = ca_q[30];
                        reg_sel_d = dq_i[0];
                        if (ca_q[30] && !ca_q[31]) begin
                            state_d = ST_REGWR;
                            cnt_d   = 5'd0;
                        end else begin
                            state_d = ST_LAT;
                            cnt_d   = lat_eff_s;
                        end
`else
                        if (ca_q[30]) begin
                            state_d = ST_DRAIN;
                            cnt_d   = 5'd0;
                        end else begin
                            state_d = ST_LAT;
                            cnt_d   = lat_eff_s;
                        end
`endif
                    end
                end
                ST_LAT: begin
                    if (cnt_q == 5'd1) begin
                        cnt_d = 5'd0;
                        if (is_read_q) begin
                            // Prefetch word 0 so it is on dq_o in the first data cycle
                            state_d = ST_READ;
                            dq_d    = rd_data_s;
                            addr_d  = addr_next_s;
                        end else begin
                            state_d = ST_WRITE;
                        end
                    end else begin
                        cnt_d = cnt_q - 5'd1;
                    end
                end
                ST_READ: begin
                    dq_d   = rd_data_s;
                    addr_d = addr_next_s;
                end
                ST_WRITE: begin
                    mem_we_s = 1'b1;
                    addr_d   = addr_next_s;
                end
                ST_REGWR: begin
`ifdef HYPERBUS_RESPONDER_REGSPACE_EN
                    cr0_we_s = reg_sel_q;
`endif
                    state_d = ST_DRAIN;
                end
                ST_DRAIN: begin
                    state_d = ST_DRAIN;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Output enables, gated combinationally by chip select and reset
    always_comb begin
        dq_oe_s   = 1'b0;
        rwds_oe_s = 1'b0;
        rwds_s    = 1'b0;
        if (!cs_ni && !rst_i) begin
            case (state_q)
                ST_IDLE: begin
                    rwds_oe_s = 1'b1;
                    rwds_s    = add_lat_i;
                end
                ST_CA: begin
                    rwds_oe_s = 1'b1;
                    rwds_s    = add_lat_q;
                end
                ST_READ: begin
                    dq_oe_s   = 1'b1;
                    rwds_oe_s = 1'b1;
                    rwds_s    = 1'b1;
                end
                default: begin
                    dq_oe_s   = 1'b0;
                    rwds_oe_s = 1'b0;
                    rwds_s    = 1'b0;
                end
            endcase
        end else begin
            dq_oe_s   = 1'b0;
            rwds_oe_s = 1'b0;
            rwds_s    = 1'b0;
        end
    end

    // Control and datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 5'd0;
            ca_q      <= 32'h0000_0000;
            lat_q     <= 4'd0;
            add_lat_q <= 1'b0;
            is_read_q <= 1'b0;
            linear_q  <= 1'b0;
            addr_q    <= '0;
            dq_q      <= 16'h0000;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ca_q      <= ca_d;
            lat_q     <= lat_d;
            add_lat_q <= add_lat_d;
            is_read_q <= is_read_d;
            linear_q  <= linear_d;
            addr_q    <= addr_d;
            dq_q      <= dq_d;
        end
    end

`ifdef HYPERBUS_RESPONDER_REGSPACE_EN
    // Register-space state; CR0 returns to its default on reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cr0_q     <= 16'h8F1F;
            is_reg_q  <= 1'b0;
            reg_sel_q <= 1'b0;
        end else begin
            is_reg_q  <= is_reg_d;
            reg_sel_q <= reg_sel_d;
            if (cr0_we_s) begin
                cr0_q <= dq_i;
            end else begin
                cr0_q <= cr0_q;
            end
        end
    end
`endif

    // Backing store: byte-masked writes, contents survive reset
    always_ff @(posedge clk_i) begin
        if (mem_we_s && !rst_i) begin
            if (!rwds_i[0]) begin
                mem_q[addr_q][7:0] <= dq_i[7:0];
            end
            if (!rwds_i[1]) begin
                mem_q[addr_q][15:8] <= dq_i[15:8];
            end
        end
    end

    assign dq_o      = dq_q;
    assign dq_oe_o   = dq_oe_s;
    assign rwds_o    = rwds_s;
    assign rwds_oe_o = rwds_oe_s;

endmodule

// File: tb/tb_hyperbus_responder.sv
// -----------------------------------------------------------------------------
// tb_hyperbus_responder
//
// Directed bench for hyperbus_responder. Bus words are driven 1 time unit
// after the rising edge and outputs are sampled on the falling edge. A
// reference memory model predicts read data; expected read words are queued
// after the CA phase and popped as data cycles arrive. Register-space
// checks are built when HYPERBUS_RESPONDER_REGSPACE_EN is defined.
// -----------------------------------------------------------------------------
module tb_hyperbus_responder;

    localparam int MEMW = 256;
    localparam logic [15:0] ID_VAL = 16'h0C81;
`ifdef HYPERBUS_RESPONDER_REGSPACE_EN
    localparam bit REGSPACE = 1'b1;
`else
    localparam bit REGSPACE = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        cs_ni = 1'b1;
    logic [15:0] dq_i = 16'h0000;
    logic [1:0]  rwds_i = 2'b00;
    logic [3:0]  lat_i = 4'd6;
    logic        add_lat_i = 1'b0;
    logic [15:0] dq_o;
    logic        dq_oe_o;
    logic        rwds_o;
    logic        rwds_oe_o;

    int n_assert = 0;
    int n_fail   = 0;

    logic [15:0] model_mem [MEMW];
    logic [15:0] cr0_model = 16'h8F1F;
    logic [15:0] exp_q [$];
    logic [17:0] wr_q  [$];   // {mask, data}

    hyperbus_responder #(.MemWords(MEMW), .IdValue(ID_VAL)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .cs_ni     (cs_ni),
        .dq_i      (dq_i),
        .rwds_i    (rwds_i),
        .lat_i     (lat_i),
        .add_lat_i (add_lat_i),
        .dq_o      (dq_o),
        .dq_oe_o   (dq_oe_o),
        .rwds_o    (rwds_o),
        .rwds_oe_o (rwds_oe_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive after the rising edge, return at the falling edge
    task automatic step(input logic cs, input logic [15:0] d, input logic [1:0] m);
        @(posedge clk_i);
        #1;
        cs_ni  = cs;
        dq_i   = d;
        rwds_i = m;
        @(negedge clk_i);
    endtask

    function automatic logic [47:0] mk_ca(input bit rd, input bit rg, input bit lin,
                                          input logic [31:0] a);
        return {rd, rg, lin, a[31:3], 13'h0000, a[2:0]};
    endfunction

    function automatic int idx(input logic [31:0] a, input bit lin, input int n);
        logic [31:0] t;
        if (lin) begin
            t = a + 32'(n);
        end else begin
            t = a;
            t[3:0] = a[3:0] + 4'(n);
        end
        return int'(t % 32'(MEMW));
    endfunction

    task automatic txn(input bit rd, input bit rg, input bit lin, input logic [31:0] a,
                       input int nw, input logic [3:0] lat, input bit al);
        logic [47:0] ca;
        logic [15:0] w [3];
        logic [17:0] wm;
        logic [15:0] ev;
        logic [15:0] cur;
        int          lcy;
        int          k;
        ca = mk_ca(rd, rg, lin, a);
        w[0] = ca[47:32];
        w[1] = ca[31:16];
        w[2] = ca[15:0];
        lat_i = lat;
        add_lat_i = al;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, w[i], 2'b00);
            chk("ca_rwds_oe", 16'(rwds_oe_o), 16'h0001);
            chk("ca_rwds", 16'(rwds_o), 16'(al));
            // Latency flag must stay as sampled in cycle 0
            if (i >= 1) add_lat_i = ~al;
        end
        lcy = ((lat == 4'd0) ? 1 : int'(lat)) * (al ? 2 : 1);
        if (rg && !REGSPACE) begin
            for (int i = 0; i < 3; i++) begin
                step(1'b0, 16'h0000, 2'b00);
                chk("drain_oe", 16'({dq_oe_o, rwds_oe_o, rwds_o}), 16'h0000);
            end
        end else if (rg && !rd) begin
            wm = wr_q.pop_front();
            step(1'b0, wm[15:0], 2'b00);
            chk("regwr_oe", 16'({dq_oe_o, rwds_oe_o}), 16'h0000);
            if (a[0]) cr0_model = wm[15:0];
            step(1'b0, 16'h7777, 2'b00);
            chk("regwr_drain_oe", 16'({dq_oe_o, rwds_oe_o}), 16'h0000);
        end else begin
            if (rd) begin
                for (int n = 0; n < nw; n++) begin
                    if (rg) exp_q.push_back(a[0] ? cr0_model : ID_VAL);
                    else    exp_q.push_back(model_mem[idx(a, lin, n)]);
                end
            end
            for (int i = 0; i < lcy; i++) begin
                step(1'b0, 16'hDEAD, 2'b00);
                chk("lat_oe", 16'({dq_oe_o, rwds_oe_o}), 16'h0000);
            end
            for (int n = 0; n < nw; n++) begin
                if (rd) begin
                    step(1'b0, 16'h0000, 2'b00);
                    n_assert++;
                    assert (exp_q.size() > 0) else begin
                        n_fail++;
                        $error("FAIL sb_empty observed=0 expected=1");
                    end
                    ev = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hXXXX;
                    chk("rd_data", dq_o, ev);
                    chk("rd_oe", 16'({dq_oe_o, rwds_oe_o, rwds_o}), 16'h0007);
                end else begin
                    wm = wr_q.pop_front();
                    step(1'b0, wm[15:0], wm[17:16]);
                    k = idx(a, lin, n);
                    cur = model_mem[k];
                    if (!wm[16]) cur[7:0]  = wm[7:0];
                    if (!wm[17]) cur[15:8] = wm[15:8];
                    model_mem[k] = cur;
                    chk("wr_oe", 16'({dq_oe_o, rwds_oe_o}), 16'h0000);
                end
            end
        end
        // Word presented as cs_ni rises must be ignored; enables drop at once
        step(1'b1, 16'hBEEF, 2'b00);
        chk("end_oe", 16'({dq_oe_o, rwds_oe_o, rwds_o}), 16'h0000);
        add_lat_i = 1'b0;
        step(1'b1, 16'h0000, 2'b00);
    endtask

    initial begin
        logic [47:0] ca;
        // Reset state
        repeat (3) @(negedge clk_i);
        chk("rst_dq", dq_o, 16'h0000);
        chk("rst_oe", 16'({dq_oe_o, rwds_oe_o, rwds_o}), 16'h0000);
        rst_i = 1'b0;
        step(1'b1, 16'h0000, 2'b00);

        // Linear write then read at 0x10, latency 6
        wr_q.push_back({2'b00, 16'h1111});
        wr_q.push_back({2'b00, 16'h2222});
        wr_q.push_back({2'b00, 16'h3333});
        wr_q.push_back({2'b00, 16'h4444});
        txn(1'b0, 1'b0, 1'b1, 32'h10, 4, 4'd6, 1'b0);
        txn(1'b1, 1'b0, 1'b1, 32'h10, 4, 4'd6, 1'b0);

        // Prefill 0..15 with their own addresses, then wrapped read at 0x0E
        for (int i = 0; i < 16; i++) wr_q.push_back({2'b00, 16'(i)});
        txn(1'b0, 1'b0, 1'b1, 32'h0, 16, 4'd1, 1'b0);
        txn(1'b1, 1'b0, 1'b0, 32'h0E, 4, 4'd2, 1'b0);

        // Linear burst wrapping past the top of the store, latency 0 behaves as 1
        for (int i = 0; i < 4; i++) wr_q.push_back({2'b00, 16'hC000 + 16'(i)});
        txn(1'b0, 1'b0, 1'b1, 32'hFE, 4, 4'd0, 1'b0);
        txn(1'b1, 1'b0, 1'b1, 32'hFE, 4, 4'd0, 1'b0);

        // Byte mask: high byte masked
        wr_q.push_back({2'b00, 16'hAAAA});
        txn(1'b0, 1'b0, 1'b1, 32'h5, 1, 4'd2, 1'b0);
        wr_q.push_back({2'b10, 16'h5555});
        txn(1'b0, 1'b0, 1'b1, 32'h5, 1, 4'd2, 1'b0);
        txn(1'b1, 1'b0, 1'b1, 32'h5, 1, 4'd2, 1'b0);
        chk("mask_model", model_mem[5], 16'hAA55);

        // Short chip-select: two CA words only, store must be untouched
        ca = mk_ca(1'b0, 1'b0, 1'b1, 32'h5);
        step(1'b0, ca[47:32], 2'b00);
        step(1'b0, ca[31:16], 2'b00);
        step(1'b1, 16'h0000, 2'b00);
        step(1'b0, 16'h0000, 2'b00);
        step(1'b1, 16'h0000, 2'b00);
        txn(1'b1, 1'b0, 1'b1, 32'h5, 1, 4'd1, 1'b0);

        // Doubled latency: 3 x 2, first data at cycle 9
        txn(1'b1, 1'b0, 1'b1, 32'h10, 4, 4'd3, 1'b1);

        // Abort after two words, then a fresh transaction
        txn(1'b1, 1'b0, 1'b1, 32'h10, 2, 4'd2, 1'b0);
        txn(1'b1, 1'b0, 1'b1, 32'h12, 2, 4'd1, 1'b0);

        // Reset in the middle of a read burst
        ca = mk_ca(1'b1, 1'b0, 1'b1, 32'h10);
        lat_i = 4'd1;
        step(1'b0, ca[47:32], 2'b00);
        step(1'b0, ca[31:16], 2'b00);
        step(1'b0, ca[15:0], 2'b00);
        step(1'b0, 16'h0000, 2'b00);
        step(1'b0, 16'h0000, 2'b00);
        chk("mid_rd_data", dq_o, 16'h1111);
        rst_i = 1'b1;
        step(1'b0, 16'h0000, 2'b00);
        chk("mid_rst_dq", dq_o, 16'h0000);
        chk("mid_rst_oe", 16'({dq_oe_o, rwds_oe_o, rwds_o}), 16'h0000);
        rst_i = 1'b0;
        step(1'b1, 16'h0000, 2'b00);
        step(1'b1, 16'h0000, 2'b00);
        // Store contents survive reset
        txn(1'b1, 1'b0, 1'b1, 32'h10, 4, 4'd2, 1'b0);

        // Register space
`ifdef HYPERBUS_RESPONDER_REGSPACE_EN
        wr_q.push_back({2'b00, 16'h1234});
        txn(1'b0, 1'b1, 1'b1, 32'h1, 1, 4'd2, 1'b0);
        txn(1'b1, 1'b1, 1'b1, 32'h1, 2, 4'd2, 1'b0);
        txn(1'b1, 1'b1, 1'b1, 32'h0, 2, 4'd2, 1'b0);
        wr_q.push_back({2'b00, 16'h9999});
        txn(1'b0, 1'b1, 1'b1, 32'h0, 1, 4'd2, 1'b0);
        txn(1'b1, 1'b1, 1'b1, 32'h0, 1, 4'd2, 1'b0);
        rst_i = 1'b1;
        step(1'b1, 16'h0000, 2'b00);
        rst_i = 1'b0;
        cr0_model = 16'h8F1F;
        step(1'b1, 16'h0000, 2'b00);
        txn(1'b1, 1'b1, 1'b1, 32'h1, 1, 4'd2, 1'b0);
`else
        txn(1'b1, 1'b1, 1'b1, 32'h1, 2, 4'd2, 1'b0);
        txn(1'b0, 1'b1, 1'b1, 32'h10, 1, 4'd2, 1'b0);
        txn(1'b1, 1'b0, 1'b1, 32'h10, 1, 4'd2, 1'b0);
`endif

        chk("sb_drained", 16'(exp_q.size()), 16'h0000);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
